// File: rtl/hazard_scoreboard_if.sv
// ID-stage issue/hazard signal bundle for hazard_scoreboard.
interface hazard_scoreboard_if #(
  parameter int unsigned REG_ADDR_W = 4
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] src1;
  logic [REG_ADDR_W-1:0] src2;
  logic                  two_src;
  logic [REG_ADDR_W-1:0] dest;
  logic                  wb_en;
  logic                  mem_ren;
  logic                  forward_en;
  logic                  freeze;
  logic                  id_kill;
  logic                  hazard;
  logic                  issue_fire;
  logic                  busy;

  modport master (
    output id_valid, src1, src2, two_src, dest, wb_en, mem_ren,
           forward_en, freeze, id_kill,
    input  hazard, issue_fire, busy
  );

  modport slave (
    input  id_valid, src1, src2, two_src, dest, wb_en, mem_ren,
           forward_en, freeze, id_kill,
    output hazard, issue_fire, busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard for ID-stage RAW hazard detection.
// Optional HAZARD_SCOREBOARD_PERF_EN adds stall_cycles / issue_count counters.
module hazard_scoreboard #(
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned WB_DIST    = 2,
  parameter int unsigned CNT_W      = 2
) (
  input  logic                clk,
  input  logic                rst,
  hazard_scoreboard_if.slave  bus
`ifdef HAZARD_SCOREBOARD_PERF_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         issue_count
`endif
);

  localparam int unsigned     NREG       = 1 << REG_ADDR_W;
  localparam logic [CNT_W-1:0] LOAD_LAT_C = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] WB_DIST_C  = CNT_W'(WB_DIST);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [CNT_W-1:0] load_val;
  logic             hazard;
  logic             issue_fire;
  logic             busy;
  logic             src1_pend;
  logic             src2_pend;

  // Checks use pre-update counts, so an instruction never waits on its own dest.
  always_comb begin
    src1_pend  = (cnt_q[bus.src1] != '0);
    src2_pend  = bus.two_src && (cnt_q[bus.src2] != '0);
    hazard     = bus.id_valid && !bus.id_kill && (src1_pend || src2_pend);
    issue_fire = bus.id_valid && !bus.id_kill && !bus.freeze && !hazard;
  end

  always_comb begin
    busy = 1'b0;
    for (int unsigned r = 0; r < NREG; r++) begin
      busy = busy | (cnt_q[r] != '0);
    end
  end

  always_comb begin
    if (!bus.forward_en) begin
      load_val = WB_DIST_C;
    end else if (bus.mem_ren) begin
      load_val = LOAD_LAT_C;
    end else begin
      load_val = '0;
    end
  end

  // A new issue to dest overrides the decrement of that register.
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (!bus.freeze) begin
        if (cnt_q[r] != '0) begin
          cnt_d[r] = cnt_q[r] - CNT_W'(1);
        end
        if (issue_fire && bus.wb_en && (bus.dest == REG_ADDR_W'(r))) begin
          cnt_d[r] = load_val;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  assign bus.hazard     = hazard;
  assign bus.issue_fire = issue_fire;
  assign bus.busy       = busy;

`ifdef HAZARD_SCOREBOARD_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] issue_q, issue_d;

  always_comb begin
    stall_d = stall_q;
    if (hazard && !bus.freeze && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
    issue_d = issue_q + {31'd0, issue_fire};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
      issue_q <= '0;
    end else begin
      stall_q <= stall_d;
      issue_q <= issue_d;
    end
  end

  assign stall_cycles = stall_q;
  assign issue_count  = issue_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed vectors, queued expectations.
module tb_hazard_scoreboard;

  logic clk;
  logic rst;

  hazard_scoreboard_if #(.REG_ADDR_W(4)) bus_if ();

`ifdef HAZARD_SCOREBOARD_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] issue_count;
`endif

  hazard_scoreboard #(
    .REG_ADDR_W(4),
    .LOAD_LAT  (1),
    .WB_DIST   (2),
    .CNT_W     (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
`ifdef HAZARD_SCOREBOARD_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .issue_count  (issue_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic  h;
    logic  f;
    logic  b;
    bit    perf;
    string nm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (bus_if.hazard !== e.h) begin
        errors++;
        $display("FAIL %s hazard got %b exp %b", e.nm, bus_if.hazard, e.h);
      end
      checks++;
      if (bus_if.issue_fire !== e.f) begin
        errors++;
        $display("FAIL %s issue_fire got %b exp %b", e.nm, bus_if.issue_fire, e.f);
      end
      checks++;
      if (bus_if.busy !== e.b) begin
        errors++;
        $display("FAIL %s busy got %b exp %b", e.nm, bus_if.busy, e.b);
      end
`ifdef HAZARD_SCOREBOARD_PERF_EN
      if (e.perf) begin
        checks++;
        if (stall_cycles !== 32'd0 || issue_count !== 32'd0) begin
          errors++;
          $display("FAIL %s perf got stall=%0d issue=%0d exp 0/0", e.nm,
                   stall_cycles, issue_count);
        end
      end
`endif
    end
  end

  task automatic step(input logic r, input logic v, input logic [3:0] s1,
                      input logic [3:0] s2, input logic two, input logic [3:0] d,
                      input logic wb, input logic mr, input logic fw,
                      input logic fz, input logic kl, input logic eh,
                      input logic ef, input logic eb, input string nm,
                      input bit perf = 1'b0);
    exp_t e;
    rst               = r;
    bus_if.id_valid   = v;
    bus_if.src1       = s1;
    bus_if.src2       = s2;
    bus_if.two_src    = two;
    bus_if.dest       = d;
    bus_if.wb_en      = wb;
    bus_if.mem_ren    = mr;
    bus_if.forward_en = fw;
    bus_if.freeze     = fz;
    bus_if.id_kill    = kl;
    e.h = eh; e.f = ef; e.b = eb; e.perf = perf; e.nm = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic eb, input string nm);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, eb, nm);
  endtask

  initial begin
    rst = 1'b0;
    bus_if.id_valid = 0; bus_if.src1 = 0; bus_if.src2 = 0; bus_if.two_src = 0;
    bus_if.dest = 0; bus_if.wb_en = 0; bus_if.mem_ren = 0; bus_if.forward_en = 1;
    bus_if.freeze = 0; bus_if.id_kill = 0;
    @(posedge clk);
    #1;
    //      r v s1 s2 2 d  wb mr fw fz kl  h f b
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, "reset_state");
    // load-use with forwarding
    step(1, 1, 0, 0, 0, 3, 1, 1, 1, 0, 0,  0, 1, 0, "ldr_r3");
    step(1, 1, 3, 0, 0, 6, 1, 0, 1, 0, 0,  1, 0, 1, "use_r3_stall");
    step(1, 1, 3, 0, 0, 6, 1, 0, 1, 0, 0,  0, 1, 0, "use_r3_go");
    idle(0, "idle_a");
    // no forwarding, src2 dependency
    step(1, 1, 0, 0, 0, 2, 1, 0, 0, 0, 0,  0, 1, 0, "add_r2_nf");
    step(1, 1, 0, 2, 1, 8, 1, 0, 0, 0, 0,  1, 0, 1, "sub_src2_st1");
    step(1, 1, 0, 2, 1, 8, 1, 0, 0, 0, 0,  1, 0, 1, "sub_src2_st2");
    step(1, 1, 0, 2, 1, 8, 1, 0, 0, 0, 0,  0, 1, 0, "sub_src2_go");
    idle(1, "r8_pend2");
    idle(1, "r8_pend1");
    idle(0, "r8_done");
    step(1, 1, 0, 0, 0, 2, 1, 0, 0, 0, 0,  0, 1, 0, "add_r2_nf_b");
    step(1, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, "src2_unread");
    idle(1, "r2_pend");
    idle(0, "r2_done");
    // freeze hold
    step(1, 1, 0, 0, 0, 5, 1, 1, 1, 0, 0,  0, 1, 0, "ldr_r5");
    step(1, 1, 5, 0, 0, 0, 0, 0, 1, 1, 0,  1, 0, 1, "frz1");
    step(1, 1, 5, 0, 0, 0, 0, 0, 1, 1, 0,  1, 0, 1, "frz2");
    step(1, 1, 5, 0, 0, 0, 0, 0, 1, 1, 0,  1, 0, 1, "frz3");
    step(1, 1, 5, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 1, "unfrz_stall");
    step(1, 1, 5, 0, 0, 0, 0, 0, 1, 0, 0,  0, 1, 0, "unfrz_go");
    step(1, 1, 0, 0, 0, 10, 1, 0, 0, 1, 0, 0, 0, 0, "frz_no_issue");
    idle(0, "frz_no_load");
    // kill and self-dependency
    step(1, 1, 0, 0, 0, 7, 1, 0, 0, 0, 1,  0, 0, 0, "kill_r7");
    step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, "read_r7");
    step(1, 1, 4, 1, 1, 4, 1, 0, 0, 0, 0,  0, 1, 0, "self_dep_r4");
    step(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, "kill_masks_hz");
    idle(1, "r4_pend");
    idle(0, "r4_done");
    // reset mid-operation, with a same-cycle issue
    step(1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0,  0, 1, 0, "add_r1_nf");
    step(0, 1, 0, 0, 0, 11, 1, 0, 0, 0, 0, 0, 1, 1, "rst_mid");
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, "post_rst_r1", 1'b1);
    // overwrite by younger forwarded ALU write
    step(1, 1, 0, 0, 0, 9, 1, 0, 0, 0, 0,  0, 1, 0, "wr_r9_nf");
    step(1, 1, 0, 0, 0, 9, 1, 0, 1, 0, 0,  0, 1, 1, "wr_r9_alu");
    step(1, 1, 9, 0, 0, 0, 0, 0, 1, 0, 0,  0, 1, 0, "read_r9");
    // mode toggle keeps in-flight count
    step(1, 1, 0, 0, 0, 12, 1, 0, 0, 0, 0, 0, 1, 0, "wr_r12_nf");
    step(1, 1, 0, 12, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1, "r12_kept1");
    step(1, 1, 0, 12, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1, "r12_kept2");
    step(1, 1, 0, 12, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, "r12_go");
    // load wins over decrement on same register
    step(1, 1, 0, 0, 0, 13, 1, 1, 1, 0, 0, 0, 1, 0, "ldr_r13");
    step(1, 1, 0, 0, 0, 13, 1, 0, 0, 0, 0, 0, 1, 1, "rewr_r13");
    step(1, 1, 13, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, "r13_st1");
    step(1, 1, 13, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, "r13_st2");
    step(1, 1, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "r13_go");
    // top register index
    step(1, 1, 0, 0, 0, 15, 1, 0, 0, 0, 0, 0, 1, 0, "wr_r15");
    step(1, 1, 0, 15, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, "r15_st1");
    step(1, 1, 0, 15, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, "r15_st2");
    step(1, 1, 0, 15, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, "r15_go");
    idle(0, "final_idle");
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending got %0d exp 0", exp_q.size());
    end
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL timeout got running exp finished");
      $fatal(1);
    end
  end

endmodule
